// File: rtl/mpe_result_packer_pkg.sv
// Shared sizing, FSM state encoding and the ReLU helper for the result packer.
package mpe_result_packer_pkg;

  localparam int LANES       = 16;
  localparam int LANE_W      = 32;
  localparam int FIFO_DEPTH  = 4;
  localparam int ADDR_W      = 12;
  localparam int WORDS_W     = 8;
  localparam int LANE_IDX_W  = $clog2(LANES);
  localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WORD_W      = LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [LANES-1:0][LANE_W-1:0] word_t;

  // Sign-bit clamp only; magnitude and width are left untouched.
  function automatic logic [LANE_W-1:0] relu_apply(input logic [LANE_W-1:0] v, input logic en);
    return (en && v[LANE_W-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/mpe_result_packer_if.sv
// PE result strobe, job configuration, NRAM write channel and status of the packer.
interface mpe_result_packer_if;
  import mpe_result_packer_pkg::*;

  logic [LANE_W-1:0]  mpe_result;
  logic               mpe_result_vld;
  logic               cfg_start;
  logic [ADDR_W-1:0]  cfg_base_addr;
  logic [WORDS_W-1:0] cfg_num_words;
  logic               cfg_relu;
  logic [WORD_W-1:0]  nram_wr_data;
  logic [ADDR_W-1:0]  nram_wr_addr;
  logic               nram_wr_valid;
  logic               nram_wr_ready;
  logic               busy;
  logic               done;
  logic               overflow;

  modport slave (
    input  mpe_result, mpe_result_vld, cfg_start, cfg_base_addr, cfg_num_words, cfg_relu,
    input  nram_wr_ready,
    output nram_wr_data, nram_wr_addr, nram_wr_valid, busy, done, overflow
  );

  modport master (
    output mpe_result, mpe_result_vld, cfg_start, cfg_base_addr, cfg_num_words, cfg_relu,
    output nram_wr_ready,
    input  nram_wr_data, nram_wr_addr, nram_wr_valid, busy, done, overflow
  );

endinterface

// File: rtl/mpe_result_packer_sync_fifo.sv
// Generic synchronous FIFO, no bypass; a push while full succeeds only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_wr      = i_push && (!o_full || i_pop);
  assign w_rd      = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= nxt_ptr(r_wr_ptr);
      end
      if (w_rd) r_rd_ptr <= nxt_ptr(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mpe_result_packer.sv
// Packs 16 PE results per 512-bit NRAM word through a 4-entry FIFO, optional ReLU.
module mpe_result_packer
  import mpe_result_packer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mpe_result_packer_if.slave  bus
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  word_t                  r_lanes;
  logic [LANE_IDX_W-1:0]  r_lane_cnt;
  logic [WORDS_W-1:0]     r_words_left;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_relu;
  logic                   r_overflow;
  logic                   w_start_acc;
  logic                   w_pop;
  logic                   w_wr_hs;
  logic                   w_drop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [LANE_W-1:0]      w_fifo_dat;
  logic [FIFO_CNT_W-1:0]  w_fifo_count;

  sync_fifo #(.WIDTH(LANE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (bus.mpe_result_vld),
    .i_push_dat (bus.mpe_result),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );

  // The PE cannot be stalled, so a push into a full FIFO with no pop is lost.
  assign w_drop = bus.mpe_result_vld && w_fifo_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_pop       = 1'b0;
    w_wr_hs     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cfg_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (bus.cfg_num_words != '0) ? ST_PACK : ST_DONE;
        end
      end
      ST_PACK: begin
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
          if (r_lane_cnt == '1) w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.nram_wr_ready) begin
          w_wr_hs     = 1'b1;
          w_state_nxt = (r_words_left == WORDS_W'(1)) ? ST_DONE : ST_PACK;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lanes      <= '0;
      r_lane_cnt   <= '0;
      r_words_left <= '0;
      r_addr       <= '0;
      r_relu       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_lanes      <= '0;
        r_lane_cnt   <= '0;
        r_words_left <= bus.cfg_num_words;
        r_addr       <= bus.cfg_base_addr;
        r_relu       <= bus.cfg_relu;
      end
      if (w_pop) begin
        r_lanes[r_lane_cnt] <= relu_apply(w_fifo_dat, r_relu);
        r_lane_cnt          <= r_lane_cnt + 1'b1;
      end
      if (w_wr_hs) begin
        r_addr       <= r_addr + 1'b1;
        r_words_left <= r_words_left - 1'b1;
      end
      // A drop in the same cycle as a new job still counts against that job.
      if (w_drop)           r_overflow <= 1'b1;
      else if (w_start_acc) r_overflow <= 1'b0;
    end
  end

  assign bus.nram_wr_data  = r_lanes;
  assign bus.nram_wr_addr  = r_addr;
  assign bus.nram_wr_valid = (r_state == ST_WRITE);
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.done          = (r_state == ST_DONE);
  assign bus.overflow      = r_overflow;

  a_fifo_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    w_fifo_count <= FIFO_CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_mpe_result_packer.sv
// Directed bench for mpe_result_packer: drives and samples 1 ns after each rising edge.
module tb_mpe_result_packer;
  import mpe_result_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mpe_result_packer_if bus();
  mpe_result_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int               n_assert = 0;
  int               n_fail   = 0;
  logic [31:0]      res_q[$];
  logic [11:0]      wr_addr_q[$];
  logic [511:0]     wr_data_q[$];
  int               stall_budget = 0;
  bit               stall_ref_set;
  bit               stall_stable;
  logic [511:0]     stall_ref_dat;
  logic [11:0]      stall_ref_addr;
  bit               inject_start = 1'b0;
  int               first_valid;
  int               first_done;
  logic [511:0]     exp_w;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_next();
    if (res_q.size() > 0) begin
      bus.mpe_result     = res_q.pop_front();
      bus.mpe_result_vld = 1'b1;
    end else begin
      bus.mpe_result     = '0;
      bus.mpe_result_vld = 1'b0;
    end
  endtask

  task automatic step();
    if (bus.nram_wr_valid && bus.nram_wr_ready) begin
      wr_addr_q.push_back(bus.nram_wr_addr);
      wr_data_q.push_back(bus.nram_wr_data);
    end
    @(posedge clk);
    #1;
    bus.cfg_start = 1'b0;
    drive_next();
    if (bus.nram_wr_valid && stall_budget > 0) begin
      bus.nram_wr_ready = 1'b0;
      stall_budget--;
      if (!stall_ref_set) begin
        stall_ref_dat  = bus.nram_wr_data;
        stall_ref_addr = bus.nram_wr_addr;
        stall_ref_set  = 1'b1;
      end else if (bus.nram_wr_data !== stall_ref_dat || bus.nram_wr_addr !== stall_ref_addr) begin
        stall_stable = 1'b0;
      end
    end else begin
      bus.nram_wr_ready = 1'b1;
    end
    if (inject_start && bus.nram_wr_valid) begin
      bus.cfg_start     = 1'b1;
      bus.cfg_base_addr = 12'h123;
      bus.cfg_num_words = 8'd5;
      inject_start      = 1'b0;
    end
  endtask

  task automatic begin_job(input logic [11:0] base, input logic [7:0] n, input logic relu);
    wr_addr_q.delete();
    wr_data_q.delete();
    bus.cfg_base_addr = base;
    bus.cfg_num_words = n;
    bus.cfg_relu      = relu;
    bus.cfg_start     = 1'b1;
  endtask

  task automatic run_job(input string tag);
    first_valid = 0;
    first_done  = 0;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (bus.nram_wr_valid && first_valid == 0) first_valid = n;
      if (bus.done) begin
        first_done = n;
        break;
      end
    end
    chk({tag, "_done_seen"}, first_done != 0, 1'b1);
    step();
    chk({tag, "_done_one_cycle"}, bus.done, 1'b0);
    chk({tag, "_idle_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.mpe_result     = '0;
    bus.mpe_result_vld = 1'b0;
    bus.cfg_start      = 1'b0;
    bus.cfg_base_addr  = '0;
    bus.cfg_num_words  = '0;
    bus.cfg_relu       = 1'b0;
    bus.nram_wr_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.nram_wr_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_data", bus.nram_wr_data, '0);
    chk("rst_addr", bus.nram_wr_addr, '0);
    rst_n = 1'b1;
    step();

    // Single word, results 1..16 back to back.
    for (int i = 1; i <= 16; i++) res_q.push_back(32'(i));
    drive_next();
    begin_job(12'h010, 8'd1, 1'b0);
    run_job("t1");
    chk("t1_valid_step", first_valid, 17);
    chk("t1_done_step", first_done, 18);
    chk("t1_nwrites", wr_addr_q.size(), 1);
    chk("t1_addr", wr_addr_q[0], 12'h010);
    chk("t1_lane0", wr_data_q[0][31:0], 32'd1);
    chk("t1_lane15", wr_data_q[0][511:480], 32'd16);
    for (int i = 0; i < 16; i++) exp_w[32*i +: 32] = 32'(i + 1);
    chk("t1_word", wr_data_q[0], exp_w);

    // ReLU on: -5 lanes clamp to 0, +7 lanes pass.
    for (int i = 0; i < 16; i++) res_q.push_back((i % 2 == 0) ? 32'hFFFF_FFFB : 32'd7);
    drive_next();
    begin_job(12'h020, 8'd1, 1'b1);
    run_job("t2");
    for (int i = 0; i < 16; i++) exp_w[32*i +: 32] = (i % 2 == 0) ? 32'd0 : 32'd7;
    chk("t2_relu_word", wr_data_q[0], exp_w);
    chk("t2_relu_lane0", wr_data_q[0][31:0], 32'd0);

    // ReLU off, with three results already queued while idle.
    for (int i = 0; i < 16; i++) res_q.push_back((i % 2 == 0) ? 32'hFFFF_FFFB : 32'd7);
    drive_next();
    step();
    step();
    step();
    chk("t2b_idle_busy", bus.busy, 1'b0);
    begin_job(12'h030, 8'd1, 1'b0);
    run_job("t2b");
    for (int i = 0; i < 16; i++) exp_w[32*i +: 32] = (i % 2 == 0) ? 32'hFFFF_FFFB : 32'd7;
    chk("t2b_raw_word", wr_data_q[0], exp_w);
    chk("t2b_addr", wr_addr_q[0], 12'h030);
    chk("t2b_no_overflow", bus.overflow, 1'b0);

    // Two words, ready held low for 10 cycles on the first write while results stream.
    for (int i = 1; i <= 40; i++) res_q.push_back(32'(i));
    stall_budget  = 10;
    stall_ref_set = 1'b0;
    stall_stable  = 1'b1;
    drive_next();
    begin_job(12'h100, 8'd2, 1'b0);
    run_job("t3");
    chk("t3_overflow", bus.overflow, 1'b1);
    chk("t3_stall_stable", stall_stable, 1'b1);
    chk("t3_stall_addr", stall_ref_addr, 12'h100);
    chk("t3_nwrites", wr_addr_q.size(), 2);
    chk("t3_addr0", wr_addr_q[0], 12'h100);
    chk("t3_addr1", wr_addr_q[1], 12'h101);
    for (int i = 0; i < 16; i++) exp_w[32*i +: 32] = 32'(i + 1);
    chk("t3_word0", wr_data_q[0], exp_w);
    for (int i = 0; i < 16; i++) exp_w[32*i +: 32] = (i < 4) ? 32'(17 + i) : 32'(25 + i);
    chk("t3_word1", wr_data_q[1], exp_w);

    // Zero-word job: straight to DONE, no write; accepted start clears overflow.
    drive_next();
    begin_job(12'h055, 8'd0, 1'b0);
    step();
    chk("t4_done", bus.done, 1'b1);
    chk("t4_busy", bus.busy, 1'b1);
    chk("t4_no_valid", bus.nram_wr_valid, 1'b0);
    chk("t4_overflow_clr", bus.overflow, 1'b0);
    step();
    chk("t4_done_low", bus.done, 1'b0);
    chk("t4_idle", bus.busy, 1'b0);
    chk("t4_no_valid2", bus.nram_wr_valid, 1'b0);

    // Reset in the middle of PACK, then a clean job.
    for (int i = 0; i < 8; i++) res_q.push_back(32'(100 + i));
    drive_next();
    begin_job(12'h200, 8'd1, 1'b0);
    repeat (6) step();
    chk("t5_busy_pre", bus.busy, 1'b1);
    res_q.delete();
    bus.mpe_result_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", bus.nram_wr_valid, 1'b0);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_done", bus.done, 1'b0);
    chk("t5_rst_overflow", bus.overflow, 1'b0);
    chk("t5_rst_data", bus.nram_wr_data, '0);
    chk("t5_rst_addr", bus.nram_wr_addr, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) res_q.push_back(32'(200 + i));
    drive_next();
    begin_job(12'h3C0, 8'd1, 1'b0);
    run_job("t5");
    chk("t5_nwrites", wr_addr_q.size(), 1);
    chk("t5_addr", wr_addr_q[0], 12'h3C0);
    for (int i = 0; i < 16; i++) exp_w[32*i +: 32] = 32'(200 + i);
    chk("t5_word", wr_data_q[0], exp_w);
    chk("t5_overflow", bus.overflow, 1'b0);

    // Start pulsed during WRITE is ignored; address wraps from 0xFFF to 0x000.
    for (int i = 1; i <= 32; i++) res_q.push_back(32'(1000 + i));
    inject_start = 1'b1;
    drive_next();
    begin_job(12'hFFF, 8'd2, 1'b0);
    run_job("t6");
    chk("t6_injected", inject_start, 1'b0);
    chk("t6_nwrites", wr_addr_q.size(), 2);
    chk("t6_addr0", wr_addr_q[0], 12'hFFF);
    chk("t6_addr1", wr_addr_q[1], 12'h000);
    for (int i = 0; i < 16; i++) exp_w[32*i +: 32] = 32'(1017 + i);
    chk("t6_word1", wr_data_q[1], exp_w);
    step();
    chk("t6_still_idle", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
